// File: rtl/ibex_instr_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_resp_pkg
// Description : Shared types and helpers for the instruction-fetch responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_instr_resp_pkg;

  // One response slot: done marks the slot ready to be returned to the core.
  typedef struct packed {
    logic        done;
    logic        err;
    logic [31:0] data;
  } resp_slot_t;

  // Width of the memory word address for a window of the given byte size.
  function automatic int unsigned calc_aw(input logic [31:0] size_bytes);
    return $clog2(size_bytes) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_instr_resp_queue.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_resp_queue
// Description : In-order response queue. Slots are pushed at grant time,
//               completed out of band by index when memory data arrives, and
//               popped from the head once done.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_instr_resp_queue
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  resp_slot_t               push_slot_i,
  output logic [$clog2(Depth)-1:0] push_idx_o,
  input  logic                     complete_i,
  input  logic [$clog2(Depth)-1:0] complete_idx_i,
  input  logic [31:0]              complete_data_i,
  input  logic                     pop_i,
  output resp_slot_t               head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o
);

  localparam int unsigned PtrW      = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  resp_slot_t      slot_q [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [PtrW:0]   count_q;

  // Slot storage: a push and a completion never target the same slot, since
  // the completing slot is occupied and the pushed slot is free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        slot_q[wptr_q] <= push_slot_i;
      end
      if (complete_i) begin
        slot_q[complete_idx_i].done <= 1'b1;
        slot_q[complete_idx_i].data <= complete_data_i;
      end
    end
  end

  // Pointers wrap naturally; count holds steady on simultaneous push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o     = slot_q[rptr_q];
  assign push_idx_o = wptr_q;
  assign count_o    = count_q;
  assign full_o     = (count_q == FullCount);

endmodule
`default_nettype wire

// File: rtl/ibex_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_mem_responder
// Description : Responder for the core instruction-fetch bus. Range-checks
//               each fetch, forwards in-window fetches to a one-cycle-latency
//               memory port, answers out-of-window fetches with an error, and
//               returns all responses strictly in request order.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_instr_mem_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h0000_0000,
  parameter logic [31:0] MemSizeBytes   = 32'h0001_0000,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               instr_req_i,
  output logic                               instr_gnt_o,
  input  logic [31:0]                        instr_addr_i,
  output logic                               instr_rvalid_o,
  output logic [31:0]                        instr_rdata_o,
  output logic                               instr_err_o,
  output logic                               mem_req_o,
  input  logic                               mem_gnt_i,
  output logic [calc_aw(MemSizeBytes)-1:0]   mem_addr_o,
  input  logic                               mem_rvalid_i,
  input  logic [31:0]                        mem_rdata_i,
  output logic                               busy_o
);

  localparam int unsigned AW   = calc_aw(MemSizeBytes);
  localparam int unsigned IdxW = $clog2(MaxOutstanding);

  logic [31:0]     offset;
  logic            addr_err;
  logic            full;
  logic [IdxW:0]   count;
  logic [IdxW-1:0] push_idx;
  resp_slot_t      head;
  resp_slot_t      push_slot;
  logic            mem_grant;
  logic            capture;
  logic            inflight_q;
  logic [IdxW-1:0] inflight_idx_q;

  // Addresses below the base wrap to large offsets and so fall out of range.
  assign offset   = instr_addr_i - MemBase;
  assign addr_err = (offset >= MemSizeBytes);
  assign mem_addr_o = offset[AW+1:2];

  // Grant depends only on registered fullness, so a pop cannot feed grant.
  assign mem_req_o   = instr_req_i & ~full & ~addr_err;
  assign instr_gnt_o = instr_req_i & ~full & (addr_err | mem_gnt_i);
  assign mem_grant   = mem_req_o & mem_gnt_i;

  // Error slots are born complete; memory slots wait for their read data.
  assign push_slot = addr_err ? resp_slot_t'{done: 1'b1, err: 1'b1, data: 32'h0}
                              : resp_slot_t'{done: 1'b0, err: 1'b0, data: 32'h0};

  assign capture = mem_rvalid_i & inflight_q;

  // Track the single memory read in flight; a back-to-back grant re-arms it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else if (mem_grant) begin
      inflight_q     <= 1'b1;
      inflight_idx_q <= push_idx;
    end else if (capture) begin
      inflight_q     <= 1'b0;
    end
  end

  ibex_instr_resp_queue #(
    .Depth (MaxOutstanding)
  ) u_queue (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .push_i          (instr_gnt_o),
    .push_slot_i     (push_slot),
    .push_idx_o      (push_idx),
    .complete_i      (capture),
    .complete_idx_i  (inflight_idx_q),
    .complete_data_i (mem_rdata_i),
    .pop_i           (instr_rvalid_o),
    .head_o          (head),
    .count_o         (count),
    .full_o          (full)
  );

  // The core never stalls rvalid, so presenting the head also pops it.
  assign instr_rvalid_o = (count != '0) & head.done;
  assign instr_err_o    = instr_rvalid_o & head.err;
  assign instr_rdata_o  = instr_rvalid_o ? head.data : 32'h0;

  assign busy_o = (count != '0) | instr_req_i;

endmodule
`default_nettype wire

// File: tb/tb_ibex_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_instr_mem_responder
// Description : Directed self-checking bench for the instruction responder,
//               with a one-cycle memory model whose response can be held off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_instr_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i = 32'h0;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [13:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic        hold = 1'b0;
  logic        pend;
  logic [13:0] pend_addr;

  ibex_instr_mem_responder dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_addr_i   (instr_addr_i),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_addr_o     (mem_addr_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: word 0x41 holds DEADBEEF, other words encode their index.
  function automatic logic [31:0] mem_word(input logic [13:0] idx);
    if (idx == 14'h41) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | {18'h0, idx};
  endfunction

  // Memory model: data one cycle after grant, or once hold is released.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= 32'h0;
      pend         <= 1'b0;
      pend_addr    <= '0;
    end else begin
      mem_rvalid_i <= 1'b0;
      if (mem_req_o && mem_gnt_i) begin
        if (hold) begin
          pend      <= 1'b1;
          pend_addr <= mem_addr_o;
        end else begin
          mem_rvalid_i <= 1'b1;
          mem_rdata_i  <= mem_word(mem_addr_o);
        end
      end else if (pend && !hold) begin
        mem_rvalid_i <= 1'b1;
        mem_rdata_i  <= mem_word(pend_addr);
        pend         <= 1'b0;
      end
    end
  end

  // Read data must only arrive while the responder expects it.
  always @(negedge clk_i) begin
    if (rst_ni && mem_rvalid_i) begin
      n_assert++;
      if (dut.inflight_q !== 1'b1) begin
        n_fail++;
        $display("FAIL stray_rvalid: inflight=%b required 1", dut.inflight_q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    n_assert++;
    if ({instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o, busy_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o, busy_o});
    end
    n_assert++;
    if (instr_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h required 0", instr_rdata_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(negedge clk_i);
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0104; mem_gnt_i = 1'b1;
    #1;
    n_assert++;
    if ({instr_gnt_o, mem_req_o, busy_o} !== 3'b111 || mem_addr_o !== 14'h41) begin
      n_fail++;
      $display("FAIL single_addr: gnt/req/busy=%b addr=%h required 111 041",
               {instr_gnt_o, mem_req_o, busy_o}, mem_addr_o);
    end
    @(negedge clk_i);
    instr_req_i = 1'b0;
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: rvalid=%b required 0", instr_rvalid_o);
    end
    @(negedge clk_i);
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hDEAD_BEEF || instr_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: rvalid=%b data=%h err=%b required 1 deadbeef 0",
               instr_rvalid_o, instr_rdata_o, instr_err_o);
    end
    @(negedge clk_i);
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: rvalid=%b busy=%b required 0 0", instr_rvalid_o, busy_o);
    end
  endtask

  task automatic test_streaming();
    int max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      instr_req_i  = (i < 8);
      instr_addr_i = 32'(i * 4);
      #1;
      if (i < 8) begin
        n_assert++;
        if (instr_gnt_o !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_gnt[%0d]: gnt=%b required 1", i, instr_gnt_o);
        end
      end
      if (i >= 2) begin
        n_assert++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(14'(i - 2)) || instr_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_resp[%0d]: rvalid=%b data=%h err=%b required 1 %h 0",
                   i, instr_rvalid_o, instr_rdata_o, instr_err_o, mem_word(14'(i - 2)));
        end
      end
      if (int'(dut.u_queue.count_q) > max_cnt) max_cnt = int'(dut.u_queue.count_q);
    end
    n_assert++;
    if (max_cnt > 2) begin
      n_fail++;
      $display("FAIL stream_count: max count %0d required <= 2", max_cnt);
    end
  endtask

  task automatic test_mem_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      instr_req_i = 1'b1; instr_addr_i = 32'h10; mem_gnt_i = 1'b0;
      #1;
      n_assert++;
      if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b0 || dut.u_queue.count_q !== 3'd0) begin
        n_fail++;
        $display("FAIL stall[%0d]: req=%b gnt=%b count=%0d required 1 0 0",
                 i, mem_req_o, instr_gnt_o, dut.u_queue.count_q);
      end
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b1;
    #1;
    n_assert++;
    if (instr_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: gnt=%b required 1", instr_gnt_o);
    end
    @(negedge clk_i);
    instr_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(14'h4)) begin
      n_fail++;
      $display("FAIL stall_resp: rvalid=%b data=%h required 1 %h",
               instr_rvalid_o, instr_rdata_o, mem_word(14'h4));
    end
  endtask

  task automatic test_error_order();
    @(negedge clk_i);
    instr_req_i = 1'b1; instr_addr_i = 32'h0;
    @(negedge clk_i);
    instr_addr_i = 32'h0002_0000;
    #1;
    n_assert++;
    if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_addr_phase: gnt=%b mreq=%b rvalid=%b required 1 0 0",
               instr_gnt_o, mem_req_o, instr_rvalid_o);
    end
    @(negedge clk_i);
    instr_addr_i = 32'h4;
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b0 || instr_rdata_o !== mem_word(14'h0)) begin
      n_fail++;
      $display("FAIL err_order0: rvalid=%b err=%b data=%h required 1 0 %h",
               instr_rvalid_o, instr_err_o, instr_rdata_o, mem_word(14'h0));
    end
    @(negedge clk_i);
    instr_req_i = 1'b0;
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b1 || instr_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL err_order1: rvalid=%b err=%b data=%h required 1 1 0",
               instr_rvalid_o, instr_err_o, instr_rdata_o);
    end
    @(negedge clk_i);
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b0 || instr_rdata_o !== mem_word(14'h1)) begin
      n_fail++;
      $display("FAIL err_order2: rvalid=%b err=%b data=%h required 1 0 %h",
               instr_rvalid_o, instr_err_o, instr_rdata_o, mem_word(14'h1));
    end
  endtask

  task automatic test_full();
    int gcnt = 0;
    hold = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      instr_req_i  = 1'b1;
      instr_addr_i = (c == 0) ? 32'h0 : (c < 4) ? 32'h0003_0000 : 32'h8;
      #1;
      gcnt += int'(instr_gnt_o);
      if (c >= 4) begin
        n_assert++;
        if (instr_gnt_o !== 1'b0 || mem_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL full_block[%0d]: gnt=%b mreq=%b required 0 0", c, instr_gnt_o, mem_req_o);
        end
      end
      if (c == 5) hold = 1'b0;
      if (c == 6) begin
        n_assert++;
        if (instr_rvalid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL full_early: rvalid=%b required 0", instr_rvalid_o);
        end
      end
      if (c == 7) begin
        n_assert++;
        if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b0 || instr_rdata_o !== mem_word(14'h0)) begin
          n_fail++;
          $display("FAIL full_pop: rvalid=%b err=%b data=%h required 1 0 %h",
                   instr_rvalid_o, instr_err_o, instr_rdata_o, mem_word(14'h0));
        end
      end
    end
    n_assert++;
    if (gcnt != 4) begin
      n_fail++;
      $display("FAIL full_grants: got %0d grants required 4", gcnt);
    end
    @(negedge clk_i);
    #1;
    n_assert++;
    if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_resume: gnt=%b mreq=%b rvalid=%b err=%b required 1 1 1 1",
               instr_gnt_o, mem_req_o, instr_rvalid_o, instr_err_o);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      instr_req_i = 1'b0;
      #1;
      n_assert++;
      if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b1) begin
        n_fail++;
        $display("FAIL full_err[%0d]: rvalid=%b err=%b required 1 1", c, instr_rvalid_o, instr_err_o);
      end
    end
    @(negedge clk_i);
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b0 || instr_rdata_o !== mem_word(14'h2)) begin
      n_fail++;
      $display("FAIL full_last: rvalid=%b err=%b data=%h required 1 0 %h",
               instr_rvalid_o, instr_err_o, instr_rdata_o, mem_word(14'h2));
    end
    @(negedge clk_i);
    #1;
    n_assert++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle: busy=%b required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      instr_req_i = 1'b1; instr_addr_i = 32'(c * 4);
    end
    @(negedge clk_i);
    instr_req_i = 1'b0;
    rst_ni      = 1'b0;
    #1;
    n_assert++;
    if ({instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o, busy_o} !== 5'b0 ||
        instr_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset: ctrl=%b data=%h required 00000 0",
               {instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o, busy_o}, instr_rdata_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    instr_req_i = 1'b1; instr_addr_i = 32'h8;
    #1;
    n_assert++;
    if (instr_gnt_o !== 1'b1 || mem_addr_o !== 14'h2) begin
      n_fail++;
      $display("FAIL post_reset_gnt: gnt=%b addr=%h required 1 002", instr_gnt_o, mem_addr_o);
    end
    @(negedge clk_i);
    instr_req_i = 1'b0;
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_early: rvalid=%b required 0", instr_rvalid_o);
    end
    @(negedge clk_i);
    #1;
    n_assert++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(14'h2) || instr_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_resp: rvalid=%b data=%h err=%b required 1 %h 0",
               instr_rvalid_o, instr_rdata_o, instr_err_o, mem_word(14'h2));
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_streaming();
    test_mem_stall();
    test_error_order();
    test_full();
    test_reset_mid();
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
